// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encoding,
// shadow stage tag layout and the bubble constant.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             load;
    } stage_tag_t;

    localparam stage_tag_t BUBBLE_TAG = '{rd: '0, regwrite: 1'b0, load: 1'b0};

endpackage

// File: rtl/hazard_tag_reg.sv
// One shadow pipeline stage tag (rd, regwrite, load). Reset and clear both
// load a bubble; otherwise the tag advances from the previous stage.
import hazard_pkg::*;

module hazard_tag_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  stage_tag_t d,
    output stage_tag_t q
);

    // Advance the tag each cycle, inserting a bubble on reset or clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= BUBBLE_TAG;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I core. Tracks destination tags of
// the E/M/W instructions, raises load-use stalls and branch flushes, and
// registers the EX operand forward selects one cycle ahead from decode.
import hazard_pkg::*;

module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    input  logic                      regwrite_d,
    input  logic                      load_d,
    input  logic                      pcsrc_e,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e
);

    stage_tag_t tag_d;
    stage_tag_t tag_e;
    stage_tag_t tag_m;
    stage_tag_t tag_w;
    logic       lwstall;
    fwd_sel_t   fwd_a_next;
    fwd_sel_t   fwd_b_next;
    fwd_sel_t   fwd_a_q;
    fwd_sel_t   fwd_b_q;

    // Youngest producer wins: current E will be in MEM, current M in WB,
    // by the time the decoding instruction reaches E. x0 never forwards.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_W-1:0] src,
        input stage_tag_t       e,
        input stage_tag_t       m
    );
        if (e.regwrite && (e.rd != '0) && (e.rd == src)) begin
            return FWD_MEM;
        end else if (m.regwrite && (m.rd != '0) && (m.rd == src)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

    assign tag_d = '{rd: rd_d, regwrite: regwrite_d, load: load_d};

    hazard_tag_reg u_tag_e (.clk(clk), .rst(rst), .clear(flush_e), .d(tag_d), .q(tag_e));
    hazard_tag_reg u_tag_m (.clk(clk), .rst(rst), .clear(1'b0),    .d(tag_e), .q(tag_m));
    hazard_tag_reg u_tag_w (.clk(clk), .rst(rst), .clear(1'b0),    .d(tag_m), .q(tag_w));

    // The W tag is kept as visible shadow state; M's load flag is not needed
    // once the load has left E. Both are folded into a sink.
    logic unused_tags;
    assign unused_tags = ^{tag_m.load, tag_w};

    // Load-use detection; rs usage is not qualified, so false stalls are accepted.
    always_comb begin
        lwstall = tag_e.load && tag_e.regwrite && (tag_e.rd != '0)
                  && ((tag_e.rd == rs1_d) || (tag_e.rd == rs2_d));
    end

    // Stall/flush controls; a taken branch kills D, so it overrides the stall.
    always_comb begin
        stall_f = lwstall && !pcsrc_e;
        stall_d = lwstall && !pcsrc_e;
        flush_d = pcsrc_e;
        flush_e = pcsrc_e || lwstall;
    end

    // Forward-select precompute for the instruction now in decode.
    always_comb begin
        fwd_a_next = fwd_select(rs1_d, tag_e, tag_m);
        fwd_b_next = fwd_select(rs2_d, tag_e, tag_m);
    end

    // Forward-select registers; a bubble entering E needs no forwarding.
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_next;
            fwd_b_q <= fwd_b_next;
        end
    end

    assign forward_a_e = fwd_a_q;
    assign forward_b_e = fwd_b_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vector table, a mid-stall reset sequence,
// and randomized traffic checked against an instruction-level reference model.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       regwrite_d, load_d, pcsrc_e;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, flush_d, flush_e;

    int pass_cnt = 0;
    int total_cnt = 0;

    hazard_unit #(.REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .regwrite_d(regwrite_d), .load_d(load_d), .pcsrc_e(pcsrc_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld, pc;
        logic       x_stall, x_fd, x_fe;
        logic [1:0] x_fa, x_fb;
    } vec_t;

    function automatic vec_t mk(input logic r, input int s1, input int s2, input int d,
                                input logic w, input logic l, input logic p,
                                input logic st, input logic fd, input logic fe,
                                input int fa, input int fb);
        vec_t v;
        v.rst = r; v.rs1 = 5'(s1); v.rs2 = 5'(s2); v.rd = 5'(d);
        v.rw = w; v.ld = l; v.pc = p;
        v.x_stall = st; v.x_fd = fd; v.x_fe = fe;
        v.x_fa = 2'(fa); v.x_fb = 2'(fb);
        return v;
    endfunction

    // Called just after a rising edge: drive, check mid-cycle, advance one edge.
    task automatic apply(input string name, input int idx, input vec_t v);
        logic [7:0] act, exp;
        rst = v.rst; rs1_d = v.rs1; rs2_d = v.rs2; rd_d = v.rd;
        regwrite_d = v.rw; load_d = v.ld; pcsrc_e = v.pc;
        #3;
        act = {stall_f, stall_d, flush_d, flush_e, forward_a_e, forward_b_e};
        exp = {v.x_stall, v.x_stall, v.x_fd, v.x_fe, v.x_fa, v.x_fb};
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got stf/std/fd/fe/fa/fb=%b, want %b", name, idx, act, exp);
        @(posedge clk);
        #1;
    endtask

    // Reference model: the last two issued instructions (E and M slots)
    // plus the selects shown while the E instruction executes.
    typedef struct { int rd; bit wr; bit ld; } instr_t;
    instr_t slot_e, slot_m;
    int     show_a, show_b;

    function automatic int src_sel(input int src);
        if (slot_e.wr && slot_e.rd != 0 && slot_e.rd == src) return 2;
        if (slot_m.wr && slot_m.rd != 0 && slot_m.rd == src) return 1;
        return 0;
    endfunction

    vec_t tbl[22];
    vec_t hs[4];

    initial begin
        rst = 1'b1; rs1_d = '0; rs2_d = '0; rd_d = '0;
        regwrite_d = 1'b0; load_d = 1'b0; pcsrc_e = 1'b0;
        @(posedge clk); #1;

        //            rst s1 s2 rd w  l  pc  st fd fe fa fb
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // reset state
        tbl[1]  = mk(0, 1, 2, 5, 1, 0, 0,  0, 0, 0, 0, 0); // add x5
        tbl[2]  = mk(0, 5, 6, 8, 1, 0, 0,  0, 0, 0, 0, 0); // sub rs1=x5
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0); // sub in E: EX-EX
        tbl[4]  = mk(0, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0, 0); // addi x7
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // nop
        tbl[6]  = mk(0, 1, 7, 9, 1, 0, 0,  0, 0, 0, 0, 0); // and rs2=x7
        tbl[7]  = mk(0, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0, 1); // and in E: WB; addi x7
        tbl[8]  = mk(0, 0, 0, 7, 1, 0, 0,  0, 0, 0, 0, 0); // addi x7 again
        tbl[9]  = mk(0, 7, 7,10, 1, 0, 0,  0, 0, 0, 0, 0); // reader x7,x7
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 2); // youngest wins
        tbl[11] = mk(0, 2, 0, 3, 1, 1, 0,  0, 0, 0, 0, 0); // lw x3
        tbl[12] = mk(0, 3, 4,11, 1, 0, 0,  1, 0, 1, 0, 0); // add rs1=x3: stall
        tbl[13] = mk(0, 3, 4,11, 1, 0, 0,  0, 0, 0, 0, 0); // held add, one bubble only
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0); // add in E: WB
        tbl[15] = mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0); // writer rd=x0
        tbl[16] = mk(0, 0, 0,12, 1, 0, 0,  0, 0, 0, 0, 0); // reader x0
        tbl[17] = mk(0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0); // load to x0
        tbl[18] = mk(0, 0, 0,13, 1, 0, 0,  0, 0, 0, 0, 0); // reader x0: no stall
        tbl[19] = mk(0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 0, 0); // lw x4
        tbl[20] = mk(0, 4, 4,14, 1, 0, 1,  0, 1, 1, 0, 0); // branch + load-use
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // bubble in E: selects 00
        for (int i = 0; i < 22; i++) apply("table", i, tbl[i]);

        // Reset asserted while a load-use stall is active.
        hs[0] = mk(0, 0, 0, 6, 1, 1, 0,  0, 0, 0, 0, 0); // lw x6
        hs[1] = mk(1, 6, 0,15, 1, 0, 0,  1, 0, 1, 0, 0); // dependent + rst
        hs[2] = mk(0, 6, 0,15, 1, 0, 0,  0, 0, 0, 0, 0); // stall released
        hs[3] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // no WB forward: tags cleared
        for (int i = 0; i < 4; i++) apply("rst_midstall", i, hs[i]);

        // Randomized traffic against the model, starting from a clean reset.
        rst = 1'b1; @(posedge clk); #1;
        slot_e = '{0, 0, 0}; slot_m = '{0, 0, 0}; show_a = 0; show_b = 0;
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            bit   lw, fe;
            v.rst = ($urandom_range(0, 39) == 0);
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.rw  = 1'($urandom_range(0, 3) != 0);
            v.ld  = 1'($urandom_range(0, 2) == 0);
            v.pc  = 1'($urandom_range(0, 7) == 0);
            lw = slot_e.ld && slot_e.wr && slot_e.rd != 0
                 && (slot_e.rd == int'(v.rs1) || slot_e.rd == int'(v.rs2));
            fe = v.pc || lw;
            v.x_stall = lw && !v.pc;
            v.x_fd = v.pc;
            v.x_fe = fe;
            v.x_fa = 2'(show_a);
            v.x_fb = 2'(show_b);
            apply("random", n, v);
            if (v.rst) begin
                slot_e = '{0, 0, 0}; slot_m = '{0, 0, 0}; show_a = 0; show_b = 0;
            end else begin
                show_a = fe ? 0 : src_sel(int'(v.rs1));
                show_b = fe ? 0 : src_sel(int'(v.rs2));
                slot_m = slot_e;
                slot_e = fe ? '{0, 0, 0} : '{int'(v.rd), v.rw, v.ld};
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
